// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the single SDRAM controller port: SPI flash reads get
// priority, host gets a slot after HOST_SLOT back-to-back SPI grants, reads have a watchdog.
module sdram_arbiter #(
  parameter int unsigned HOST_SLOT    = 4,
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [7:0]  TIMEOUT_DATA = 8'hFF
) (
  input  logic        clk_96mhz,
  input  logic        reset,
  input  logic        spi_req,
  input  logic [24:0] spi_addr,
  output logic        spi_ack,
  output logic [7:0]  spi_rdata,
  output logic        spi_rvalid,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [24:0] host_addr,
  input  logic [7:0]  host_wdata,
  output logic        host_ack,
  output logic [7:0]  host_rdata,
  output logic        host_rvalid,
  output logic        sd_rd_enable,
  output logic [24:0] sd_rd_addr,
  output logic        sd_wr_enable,
  output logic [24:0] sd_wr_addr,
  output logic [7:0]  sd_wr_data,
  input  logic [7:0]  sd_rd_data,
  input  logic        sd_rd_ready,
  input  logic        sd_busy,
  output logic        timeout_err
);

  localparam int unsigned STARVE_W = ($clog2(HOST_SLOT + 1) > 3) ? $clog2(HOST_SLOT + 1) : 3;
  localparam int unsigned WD_W     = ($clog2(TIMEOUT) > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [STARVE_W-1:0] SLOT_FULL = STARVE_W'(HOST_SLOT);
  localparam logic [WD_W-1:0]     WD_LAST   = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, GUARD, RD_WAIT, WR_WAIT} state_e;

  state_e              state_q, state_d;
  logic                owner_host_q, owner_host_d;
  logic                we_q, we_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic [WD_W-1:0]     wd_q, wd_d;

  logic        spi_ack_q, spi_ack_d;
  logic [7:0]  spi_rdata_q, spi_rdata_d;
  logic        spi_rvalid_q, spi_rvalid_d;
  logic        host_ack_q, host_ack_d;
  logic [7:0]  host_rdata_q, host_rdata_d;
  logic        host_rvalid_q, host_rvalid_d;
  logic        rd_en_q, rd_en_d;
  logic [24:0] rd_addr_q, rd_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [24:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        terr_q, terr_d;

  logic        grant_spi_s, grant_host_s;
  logic        rd_done_s;
  logic [7:0]  rd_val_s;

  // Next-state, arbitration and output-register inputs
  always_comb begin
    state_d       = state_q;
    owner_host_d  = owner_host_q;
    we_d          = we_q;
    wd_d          = wd_q;
    spi_ack_d     = 1'b0;
    host_ack_d    = 1'b0;
    spi_rvalid_d  = 1'b0;
    host_rvalid_d = 1'b0;
    rd_en_d       = 1'b0;
    wr_en_d       = 1'b0;
    spi_rdata_d   = spi_rdata_q;
    host_rdata_d  = host_rdata_q;
    rd_addr_d     = rd_addr_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    terr_d        = terr_q;
    grant_spi_s   = 1'b0;
    grant_host_s  = 1'b0;
    rd_done_s     = 1'b0;
    rd_val_s      = 8'h00;

    case (state_q)
      IDLE: begin
        // sd_busy high means refresh in progress: hold off selection entirely
        if (!sd_busy && (spi_req || host_req)) begin
          if (host_req && (!spi_req || starve_q == SLOT_FULL)) begin
            grant_host_s = 1'b1;
          end else begin
            grant_spi_s = 1'b1;
          end
          owner_host_d = grant_host_s;
          we_d         = grant_host_s & host_we;
          host_ack_d   = grant_host_s;
          spi_ack_d    = grant_spi_s;
          if (grant_host_s && host_we) begin
            wr_en_d   = 1'b1;
            wr_addr_d = host_addr;
            wr_data_d = host_wdata;
          end else begin
            rd_en_d   = 1'b1;
            rd_addr_d = grant_host_s ? host_addr : spi_addr;
          end
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: state_d = GUARD;
      GUARD: begin
        wd_d    = '0;
        state_d = we_q ? WR_WAIT : RD_WAIT;
      end
      RD_WAIT: begin
        if (sd_rd_ready) begin
          rd_done_s = 1'b1;
          rd_val_s  = sd_rd_data;
        end else if (wd_q == WD_LAST) begin
          rd_done_s = 1'b1;
          rd_val_s  = TIMEOUT_DATA;
          terr_d    = 1'b1;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      WR_WAIT: begin
        if (!sd_busy) begin
          state_d = IDLE;
        end else begin
          state_d = WR_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (rd_done_s) begin
      state_d = IDLE;
      if (owner_host_q) begin
        host_rdata_d  = rd_val_s;
        host_rvalid_d = 1'b1;
      end else begin
        spi_rdata_d  = rd_val_s;
        spi_rvalid_d = 1'b1;
      end
    end else begin
      rd_val_s = 8'h00;
    end

    // Host wait counter: only counts SPI grants that overtook a waiting host
    if (!host_req || grant_host_s) begin
      starve_d = '0;
    end else if (grant_spi_s && starve_q != {STARVE_W{1'b1}}) begin
      starve_d = starve_q + 1'b1;
    end else begin
      starve_d = starve_q;
    end
  end

  // State and output registers
  always_ff @(posedge clk_96mhz) begin
    if (reset) begin
      state_q       <= IDLE;
      owner_host_q  <= 1'b0;
      we_q          <= 1'b0;
      starve_q      <= '0;
      wd_q          <= '0;
      spi_ack_q     <= 1'b0;
      spi_rdata_q   <= 8'h00;
      spi_rvalid_q  <= 1'b0;
      host_ack_q    <= 1'b0;
      host_rdata_q  <= 8'h00;
      host_rvalid_q <= 1'b0;
      rd_en_q       <= 1'b0;
      rd_addr_q     <= 25'h0;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= 25'h0;
      wr_data_q     <= 8'h00;
      terr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      owner_host_q  <= owner_host_d;
      we_q          <= we_d;
      starve_q      <= starve_d;
      wd_q          <= wd_d;
      spi_ack_q     <= spi_ack_d;
      spi_rdata_q   <= spi_rdata_d;
      spi_rvalid_q  <= spi_rvalid_d;
      host_ack_q    <= host_ack_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
      rd_en_q       <= rd_en_d;
      rd_addr_q     <= rd_addr_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      terr_q        <= terr_d;
    end
  end

  assign spi_ack      = spi_ack_q;
  assign spi_rdata    = spi_rdata_q;
  assign spi_rvalid   = spi_rvalid_q;
  assign host_ack     = host_ack_q;
  assign host_rdata   = host_rdata_q;
  assign host_rvalid  = host_rvalid_q;
  assign sd_rd_enable = rd_en_q;
  assign sd_rd_addr   = rd_addr_q;
  assign sd_wr_enable = wr_en_q;
  assign sd_wr_addr   = wr_addr_q;
  assign sd_wr_data   = wr_data_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomised bench for sdram_arbiter: transaction-level reference model checked every
// cycle, a behavioural SDRAM controller, and directed scenarios with literal expectations.
module tb_sdram_arbiter;
  localparam int HOST_SLOT = 4;
  localparam int TIMEOUT   = 64;

  logic        clk_96mhz = 1'b0;
  logic        reset = 1'b1;
  logic        spi_req = 1'b0;
  logic [24:0] spi_addr = 25'h0;
  logic        host_req = 1'b0;
  logic        host_we = 1'b0;
  logic [24:0] host_addr = 25'h0;
  logic [7:0]  host_wdata = 8'h00;
  logic [7:0]  sd_rd_data = 8'h00;
  logic        sd_rd_ready = 1'b0;
  logic        sd_busy = 1'b0;
  logic        spi_ack, spi_rvalid, host_ack, host_rvalid;
  logic [7:0]  spi_rdata, host_rdata, sd_wr_data;
  logic        sd_rd_enable, sd_wr_enable, timeout_err;
  logic [24:0] sd_rd_addr, sd_wr_addr;

  sdram_arbiter #(.HOST_SLOT(HOST_SLOT), .TIMEOUT(TIMEOUT), .TIMEOUT_DATA(8'hFF)) dut (
    .clk_96mhz(clk_96mhz), .reset(reset),
    .spi_req(spi_req), .spi_addr(spi_addr), .spi_ack(spi_ack),
    .spi_rdata(spi_rdata), .spi_rvalid(spi_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_ack(host_ack), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .sd_rd_enable(sd_rd_enable), .sd_rd_addr(sd_rd_addr),
    .sd_wr_enable(sd_wr_enable), .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy),
    .timeout_err(timeout_err)
  );

  always #5 clk_96mhz = ~clk_96mhz;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural SDRAM controller ----------------
  logic [7:0]  mem [logic [24:0]];
  int          lat = 4;
  bit          no_ready = 1'b0;
  bit          force_busy = 1'b0;
  int          ctl_cnt = 0;
  bit          pend_rd = 1'b0;
  logic [24:0] pend_addr = 25'h0;

  function automatic logic [7:0] mem_rd(input logic [24:0] a);
    if (mem.exists(a)) return mem[a];
    return a[7:0] ^ 8'h3C;
  endfunction

  always @(negedge clk_96mhz) begin
    sd_rd_ready = 1'b0;
    if (sd_rd_enable) begin
      pend_rd = 1'b1; pend_addr = sd_rd_addr; ctl_cnt = lat; sd_busy = 1'b1;
    end else if (sd_wr_enable) begin
      mem[sd_wr_addr] = sd_wr_data; pend_rd = 1'b0; ctl_cnt = lat; sd_busy = 1'b1;
    end else if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) begin
        sd_busy = force_busy;
        if (pend_rd && !no_ready) begin
          sd_rd_ready = 1'b1;
          sd_rd_data  = mem_rd(pend_addr);
        end
      end
    end else begin
      sd_busy = force_busy;
    end
  end

  // ---------------- requesters: hold request until acknowledged ----------------
  typedef struct packed { logic we; logic [24:0] addr; logic [7:0] wd; } host_op_t;
  logic [24:0] spi_q[$];
  host_op_t    host_q[$];

  always @(negedge clk_96mhz) begin
    host_op_t op;
    if (spi_req && spi_ack) spi_req = 1'b0;
    if (!spi_req && spi_q.size() > 0) begin
      spi_addr = spi_q.pop_front();
      spi_req  = 1'b1;
    end
    if (host_req && host_ack) host_req = 1'b0;
    if (!host_req && host_q.size() > 0) begin
      op = host_q.pop_front();
      host_we = op.we; host_addr = op.addr; host_wdata = op.wd;
      host_req = 1'b1;
    end
  end

  // ---------------- observation log ----------------
  int n_spi_ack = 0, n_host_ack = 0, n_wr = 0, n_spi_rv = 0, n_host_rv = 0;
  logic [24:0] last_wr_addr = 25'h0;
  logic [7:0]  last_wr_data = 8'h00, last_spi_rd = 8'h00, last_host_rd = 8'h00;
  bit          grant_q[$];
  logic [24:0] rdaddr_q[$];

  always @(negedge clk_96mhz) begin
    if (spi_ack)  begin n_spi_ack++;  grant_q.push_back(1'b0); end
    if (host_ack) begin n_host_ack++; grant_q.push_back(1'b1); end
    if (sd_wr_enable) begin n_wr++; last_wr_addr = sd_wr_addr; last_wr_data = sd_wr_data; end
    if (sd_rd_enable) rdaddr_q.push_back(sd_rd_addr);
    if (spi_rvalid)  begin n_spi_rv++;  last_spi_rd = spi_rdata; end
    if (host_rvalid) begin n_host_rv++; last_host_rd = host_rdata; end
  end

  // ---------------- transaction-level reference model ----------------
  bit          m_free = 1'b1;
  int          m_age = 0;
  bit          m_host = 1'b0, m_we = 1'b0;
  int          m_starve = 0;
  logic        e_spi_ack = 1'b0, e_spi_rv = 1'b0, e_host_ack = 1'b0, e_host_rv = 1'b0;
  logic        e_rd_en = 1'b0, e_wr_en = 1'b0, e_terr = 1'b0;
  logic [7:0]  e_spi_rd = 8'h00, e_host_rd = 8'h00, e_wr_data = 8'h00;
  logic [24:0] e_rd_addr = 25'h0, e_wr_addr = 25'h0;

  wire [80:0] dut_vec = {spi_ack, spi_rdata, spi_rvalid, host_ack, host_rdata, host_rvalid,
                         sd_rd_enable, sd_rd_addr, sd_wr_enable, sd_wr_addr, sd_wr_data, timeout_err};
  wire [80:0] exp_vec = {e_spi_ack, e_spi_rd, e_spi_rv, e_host_ack, e_host_rd, e_host_rv,
                         e_rd_en, e_rd_addr, e_wr_en, e_wr_addr, e_wr_data, e_terr};

  task automatic deliver(input logic [7:0] d);
    if (m_host) begin e_host_rd = d; e_host_rv = 1'b1; end
    else        begin e_spi_rd  = d; e_spi_rv  = 1'b1; end
    m_free = 1'b1;
  endtask

  always @(posedge clk_96mhz) begin
    bit gs, gh;
    gs = 1'b0; gh = 1'b0;
    e_spi_ack = 1'b0; e_host_ack = 1'b0; e_spi_rv = 1'b0; e_host_rv = 1'b0;
    e_rd_en = 1'b0; e_wr_en = 1'b0;
    if (reset) begin
      e_spi_rd = 8'h00; e_host_rd = 8'h00; e_wr_data = 8'h00;
      e_rd_addr = 25'h0; e_wr_addr = 25'h0; e_terr = 1'b0;
      m_free = 1'b1; m_starve = 0;
    end else begin
      if (m_free) begin
        if (!sd_busy && (spi_req || host_req)) begin
          gh = host_req && (!spi_req || m_starve == HOST_SLOT);
          gs = !gh;
          m_free = 1'b0; m_age = 0; m_host = gh; m_we = gh && host_we;
          if (m_we) begin e_wr_en = 1'b1; e_wr_addr = host_addr; e_wr_data = host_wdata; end
          else begin e_rd_en = 1'b1; e_rd_addr = gh ? host_addr : spi_addr; end
          if (gh) e_host_ack = 1'b1; else e_spi_ack = 1'b1;
        end
      end else begin
        m_age++;
        // two cycles of issue/guard after selection, then the wait phase
        if (m_age >= 3) begin
          if (m_we) begin
            if (!sd_busy) m_free = 1'b1;
          end else if (sd_rd_ready) begin
            deliver(sd_rd_data);
          end else if (m_age - 2 == TIMEOUT) begin
            deliver(8'hFF);
            e_terr = 1'b1;
          end
        end
      end
      if (!host_req || gh) m_starve = 0;
      else if (gs && m_starve < 7) m_starve++;
    end
    #1;
    check("cycle", 128'(dut_vec), 128'(exp_vec));
  end

  task automatic wait_quiet(input int max_cyc, input string name);
    int n;
    n = 0;
    while (!(spi_q.size() == 0 && host_q.size() == 0 && !spi_req && !host_req &&
             m_free && ctl_cnt == 0 && !sd_busy) && n < max_cyc) begin
      @(negedge clk_96mhz);
      n++;
    end
    if (n >= max_cyc) begin
      total++; bad++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
    repeat (3) @(negedge clk_96mhz);
  endtask

  initial begin
    int n0, n1, w;
    logic [5:0] g;
    host_op_t op;

    repeat (3) @(negedge clk_96mhz);
    check("reset_outs", 128'(dut_vec), 128'h0);
    reset = 1'b0;

    // 1: host write then read-back
    lat = 4;
    host_q.push_back({1'b1, 25'h0000123, 8'hA5});
    wait_quiet(200, "t1_wr");
    check("t1_write", {8'(n_wr), 8'(n_host_ack), 25'(last_wr_addr), last_wr_data},
          {8'd1, 8'd1, 25'h0000123, 8'hA5});
    lat = 6;
    host_q.push_back({1'b0, 25'h0000123, 8'h00});
    wait_quiet(200, "t1_rd");
    check("t1_read", {8'(n_host_rv), last_host_rd}, {8'd1, 8'hA5});

    // 2: simultaneous requests, SPI first
    grant_q.delete(); rdaddr_q.delete();
    n0 = n_spi_rv; n1 = n_host_rv;
    spi_q.push_back(25'h10);
    host_q.push_back({1'b0, 25'h20, 8'h00});
    wait_quiet(300, "t2");
    check("t2_order", {8'(grant_q.size()), 1'(grant_q[0]), 1'(grant_q[1])}, {8'd2, 1'b0, 1'b1});
    check("t2_addrs", {rdaddr_q[0], rdaddr_q[1]}, {25'h10, 25'h20});
    check("t2_rdata", {8'(n_spi_rv - n0), 8'(n_host_rv - n1), last_spi_rd, last_host_rd},
          {8'd1, 8'd1, 8'h2C, 8'h1C});

    // 3: both held continuously -> S,S,S,S,H,S
    grant_q.delete();
    lat = 2;
    for (int i = 0; i < 6; i++) spi_q.push_back(25'(32'h100 + i));
    for (int i = 0; i < 2; i++) host_q.push_back({1'b0, 25'(32'h200 + i), 8'h00});
    wait_quiet(600, "t3");
    for (int i = 0; i < 6; i++) g[5 - i] = grant_q[i];
    check("t3_slots", 6'(g), 6'b000010);

    // 4: read watchdog
    no_ready = 1'b1;
    n0 = n_spi_rv;
    spi_q.push_back(25'h40);
    wait_quiet(300, "t4_to");
    check("t4_timeout", {8'(n_spi_rv - n0), last_spi_rd, 1'(timeout_err)}, {8'd1, 8'hFF, 1'b1});
    no_ready = 1'b0;
    spi_q.push_back(25'h41);
    wait_quiet(300, "t4_next");
    check("t4_next", {8'(n_spi_rv - n0), last_spi_rd, 1'(timeout_err)}, {8'd2, 8'h7D, 1'b1});

    // 5: controller busy blocks selection
    force_busy = 1'b1;
    repeat (2) @(negedge clk_96mhz);
    n0 = n_host_ack; n1 = n_wr;
    host_q.push_back({1'b1, 25'h300, 8'h5A});
    repeat (20) @(negedge clk_96mhz);
    check("t5_blocked", {8'(n_host_ack - n0), 8'(n_wr - n1)}, {8'd0, 8'd0});
    force_busy = 1'b0;
    wait_quiet(200, "t5");
    check("t5_release", {8'(n_host_ack - n0), 8'(n_wr - n1), last_wr_data}, {8'd1, 8'd1, 8'h5A});

    // 6: reset during a read wait, late rd_ready ignored
    lat = 6;
    n0 = n_spi_rv; n1 = n_host_rv;
    spi_q.push_back(25'h77);
    w = 0;
    while (!sd_rd_enable && w < 50) begin @(negedge clk_96mhz); w++; end
    check("t6_issue", 1'(sd_rd_enable), 1'b1);
    repeat (2) @(negedge clk_96mhz);
    reset = 1'b1;
    @(negedge clk_96mhz);
    check("t6_zero", 128'(dut_vec), 128'h0);
    reset = 1'b0;
    repeat (8) @(negedge clk_96mhz);
    check("t6_norv", {8'(n_spi_rv - n0), 8'(n_host_rv - n1), 1'(timeout_err)}, {8'd0, 8'd0, 1'b0});

    // random traffic
    for (int i = 0; i < 120; i++) begin
      lat = $urandom_range(1, 8);
      if ($urandom_range(0, 2) != 0) spi_q.push_back(25'($urandom()));
      if ($urandom_range(0, 1) != 0) begin
        op.we = 1'($urandom_range(0, 1)); op.addr = 25'($urandom()); op.wd = 8'($urandom());
        host_q.push_back(op);
      end
      if ($urandom_range(0, 9) == 0) begin
        force_busy = 1'b1;
        repeat ($urandom_range(1, 6)) @(negedge clk_96mhz);
        force_busy = 1'b0;
      end
      repeat ($urandom_range(0, 12)) @(negedge clk_96mhz);
    end
    wait_quiet(20000, "random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
